// File: rtl/vmask_pkg.sv
// Shared opcode, FSM state and result constants for the mask-reduction sequencer.
package vmask_pkg;

  localparam logic MASK_OP_CPOP  = 1'b0;
  localparam logic MASK_OP_FIRST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } vmask_state_e;

  // vfirst.m result when no active element is set.
  localparam logic [63:0] MASK_NOT_FOUND = '1;

endpackage

// File: rtl/vmask_chunk_scan.sv
// Single-chunk scan: masks bits at or beyond vl, then reports popcount,
// lowest set bit index and a hit flag.
module vmask_chunk_scan #(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int DATA_WIDTH_BITS = 6,
  parameter int VL_BITS         = 16,
  parameter int BEAT_BITS       = VL_BITS - DATA_WIDTH_BITS + 1
) (
  input  logic [REQ_DATA_WIDTH-1:0]  chunk,
  input  logic [VL_BITS-1:0]         vl,
  input  logic [BEAT_BITS-1:0]       beat,
  output logic [DATA_WIDTH_BITS:0]   cnt,
  output logic [DATA_WIDTH_BITS-1:0] idx,
  output logic                       hit
);

  localparam int REM_BITS = VL_BITS + 2;

  logic signed [REM_BITS-1:0] rem;
  logic [REQ_DATA_WIDTH-1:0]  keep;
  logic [REQ_DATA_WIDTH-1:0]  masked;

  // rem is the number of still-active elements from this chunk's first bit on.
  always_comb begin
    rem = $signed(REM_BITS'(vl)) - $signed(REM_BITS'({beat, {DATA_WIDTH_BITS{1'b0}}}));
    if (rem >= $signed(REM_BITS'(REQ_DATA_WIDTH))) begin
      keep = '1;
    end else if (rem <= 0) begin
      keep = '0;
    end else begin
      keep = ~({REQ_DATA_WIDTH{1'b1}} << rem[DATA_WIDTH_BITS-1:0]);
    end
    masked = chunk & keep;
  end

  always_comb begin
    cnt = '0;
    idx = '0;
    hit = |masked;
    for (int i = 0; i < REQ_DATA_WIDTH; i++) begin
      cnt = cnt + (DATA_WIDTH_BITS+1)'(masked[i]);
    end
    for (int i = REQ_DATA_WIDTH - 1; i >= 0; i--) begin
      if (masked[i]) idx = DATA_WIDTH_BITS'(i);
    end
  end

endmodule

// File: rtl/vmask_reduce_seq.sv
// Multi-beat vcpop.m / vfirst.m sequencer: scan stage s0, accumulate, one-cycle result.
// Handshake: a beat is taken on a cycle where in_valid && in_ready; nothing is buffered.
module vmask_reduce_seq
  import vmask_pkg::*;
#(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int DATA_WIDTH_BITS = 6,
  parameter int VL_BITS         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_start,
  input  logic                       in_last,
  input  logic                       in_op,
  input  logic [VL_BITS-1:0]         in_vl,
  input  logic [REQ_DATA_WIDTH-1:0]  in_m0,
  output logic                       out_valid,
  output logic [RESP_DATA_WIDTH-1:0] out_data
);

  localparam int BEAT_BITS = VL_BITS - DATA_WIDTH_BITS + 1;

  vmask_state_e               state;
  logic                       op_q;
  logic [VL_BITS-1:0]         vl_q;
  logic [BEAT_BITS-1:0]       beat_cnt;
  logic                       s0_valid;
  logic [DATA_WIDTH_BITS:0]   s0_cnt;
  logic [DATA_WIDTH_BITS-1:0] s0_idx;
  logic                       s0_hit;
  logic [BEAT_BITS-1:0]       s0_beat;
  logic [RESP_DATA_WIDTH-1:0] acc;
  logic                       found;
  logic [RESP_DATA_WIDTH-1:0] first;

  logic                       accept;
  logic                       start_beat;
  logic                       op_beat;
  logic [VL_BITS-1:0]         cur_vl;
  logic [BEAT_BITS-1:0]       cur_beat;
  logic [DATA_WIDTH_BITS:0]   scan_cnt;
  logic [DATA_WIDTH_BITS-1:0] scan_idx;
  logic                       scan_hit;
  logic [RESP_DATA_WIDTH-1:0] acc_nxt;
  logic                       found_nxt;
  logic [RESP_DATA_WIDTH-1:0] first_nxt;
  logic [RESP_DATA_WIDTH-1:0] result_nxt;

  assign in_ready   = !rst && (state == ST_IDLE || state == ST_BUSY);
  assign accept     = in_valid && in_ready;
  assign start_beat = accept && in_start;
  // Only start beats open an op from IDLE; in BUSY every beat belongs to the op.
  assign op_beat    = accept && (in_start || state == ST_BUSY);
  assign cur_vl     = in_start ? in_vl : vl_q;
  assign cur_beat   = in_start ? '0 : beat_cnt;

  vmask_chunk_scan #(
    .REQ_DATA_WIDTH (REQ_DATA_WIDTH),
    .DATA_WIDTH_BITS(DATA_WIDTH_BITS),
    .VL_BITS        (VL_BITS),
    .BEAT_BITS      (BEAT_BITS)
  ) u_scan (
    .chunk(in_m0),
    .vl   (cur_vl),
    .beat (cur_beat),
    .cnt  (scan_cnt),
    .idx  (scan_idx),
    .hit  (scan_hit)
  );

  always_comb begin
    acc_nxt   = acc;
    found_nxt = found;
    first_nxt = first;
    if (s0_valid) begin
      acc_nxt = acc + RESP_DATA_WIDTH'(s0_cnt);
      if (!found && s0_hit) begin
        found_nxt = 1'b1;
        first_nxt = RESP_DATA_WIDTH'({s0_beat, s0_idx});
      end
    end
    if (op_q == MASK_OP_FIRST) begin
      result_nxt = found_nxt ? first_nxt : RESP_DATA_WIDTH'(MASK_NOT_FOUND);
    end else begin
      result_nxt = acc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= MASK_OP_CPOP;
      vl_q      <= '0;
      beat_cnt  <= '0;
      s0_valid  <= 1'b0;
      s0_cnt    <= '0;
      s0_idx    <= '0;
      s0_hit    <= 1'b0;
      s0_beat   <= '0;
      acc       <= '0;
      found     <= 1'b0;
      first     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      s0_valid  <= op_beat;
      if (op_beat) begin
        s0_cnt  <= scan_cnt;
        s0_idx  <= scan_idx;
        s0_hit  <= scan_hit;
        s0_beat <= cur_beat;
      end
      // A restart drops whatever the old op still had in s0.
      if (start_beat) begin
        op_q     <= in_op;
        vl_q     <= in_vl;
        beat_cnt <= BEAT_BITS'(1);
        acc      <= '0;
        found    <= 1'b0;
        first    <= '0;
      end else begin
        acc   <= acc_nxt;
        found <= found_nxt;
        first <= first_nxt;
        if (op_beat && beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
      end
      case (state)
        ST_IDLE: if (start_beat) state <= in_last ? ST_WAIT : ST_BUSY;
        ST_BUSY: if (accept && in_last) state <= ST_WAIT;
        ST_WAIT: begin
          out_valid <= 1'b1;
          out_data  <= result_nxt;
          state     <= ST_RESP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vmask_reduce_seq.md
Name: vmask_reduce_seq

Overview:
- Multi-beat mask-reduction sequencer for vcpop.m and vfirst.m.
- Accepts a mask register as a stream of REQ_DATA_WIDTH-bit chunks, zeroes tail bits beyond vl, and pipelines per-chunk popcount / first-set index.
- Accumulates across beats and returns one scalar result to the vALU writeback mux.
- Sits between the mask-register read port and the scalar result path.

Parameters:
- REQ_DATA_WIDTH, 64, mask bits per input beat.
- RESP_DATA_WIDTH, 64, scalar result width.
- DATA_WIDTH_BITS, 6, log2(REQ_DATA_WIDTH).
- VL_BITS, 16, width of the vl operand.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat; beat taken when in_valid && in_ready.
- in_start  in  1  first beat of an operation; latches in_op and in_vl.
- in_last  in  1  final beat of the operation.
- in_op  in  1  0 = cpop, 1 = first; sampled on the start beat only.
- in_vl  in  VL_BITS  active element count; sampled on the start beat only.
- in_m0  in  REQ_DATA_WIDTH  mask chunk; bit i = element beat*REQ_DATA_WIDTH+i.
- out_valid  out  1  one-cycle result pulse.
- out_data  out  RESP_DATA_WIDTH  result.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: FSM=IDLE, all counters/accumulators 0, s0 stage invalid, out_valid=0, out_data=0, in_ready=0 during the rst cycle.
- Reset mid-operation aborts silently; no out_valid is ever produced for the aborted op.
- FSM states IDLE, BUSY, WAIT, RESP. in_ready=1 in IDLE and BUSY only.
- IDLE:
  - Accepted beat without in_start is discarded.
  - Accepted beat with in_start: latch op/vl, beat counter=0, clear acc/found. Go to BUSY, or to WAIT if in_last is also set.
- BUSY:
  - Each accepted beat advances the beat counter; in_last goes to WAIT.
  - An accepted beat with in_start restarts: acc/found cleared, op/vl relatched, and that beat is processed as beat 0 of the new op. Any in-flight s0 beat of the old op is squashed.
- WAIT: one cycle, drains s0 into the accumulator. Next state RESP.
- RESP: out_valid=1 for exactly one cycle with out_data, then IDLE.
- Latency: out_valid is high exactly 2 cycles after the cycle the last beat was accepted. Minimum issue interval between ops is 3 cycles after the last beat.
- Tail masking (combinational, at accept):
  - rem = vl - beat*REQ_DATA_WIDTH, evaluated as signed/saturating.
  - rem >= REQ_DATA_WIDTH: chunk unmasked.
  - 0 < rem < REQ_DATA_WIDTH: only bits [rem-1:0] kept.
  - rem <= 0: chunk forced to 0.
- Stage s0 (registered): popcount of the masked chunk (DATA_WIDTH_BITS+1 bits), index of its lowest set bit, hit flag, beat number, last flag.
- Accumulate (cycle after s0):
  - acc += s0 popcount, zero-extended to RESP_DATA_WIDTH.
  - If !found && hit: found=1, first = beat*REQ_DATA_WIDTH + idx.
- Result:
  - cpop: out_data = acc.
  - first: out_data = first if found, else all ones (-1).
- Beat counter saturates at its maximum; beats beyond vl contribute 0.
- Boundary cases:
  - vl=0 gives cpop 0 and first -1.
  - More beats than vl requires are legal and contribute nothing.
  - in_valid while in_ready=0 is ignored; nothing is buffered.

Decomposition:
- Shared package vmask_pkg: opcode constants MASK_OP_CPOP=0 and MASK_OP_FIRST=1; FSM state encoding; result constant for "not found" (all ones).
- One sub-module, vmask_chunk_scan: combinational tail mask, popcount, lowest-set-bit index and hit for a single chunk. Instantiated once, in front of the s0 registers.

Test Plan:
- cpop, vl=64, one beat in_m0=0xFF00FF00FF00FF00, start+last -> out_valid 2 cycles later, out_data=32.
- cpop, vl=10, one beat in_m0=all ones -> out_data=10 (tail bits ignored).
- cpop, vl=130, three beats all ones, last on beat 2 -> out_data=130. in_ready low in WAIT/RESP; a beat presented then is dropped.
- first, vl=128: beat0=0, beat1=0x0000000000000100 -> out_data=72. first, vl=128, both beats 0 -> out_data=0xFFFFFFFFFFFFFFFF.
- first, vl=5, in_m0=0x20 (bit 5 beyond vl) -> out_data=-1. cpop with vl=0 -> 0.
- rst asserted in BUSY after 1 of 3 beats -> no out_valid; a following cpop vl=64 of 0x1 returns 1. in_start in BUSY -> result reflects the new op only.
